// File: rtl/imem_tap_sequencer.sv
// imem_tap_sequencer: coefficient bank plus a tap sequencer feeding the imem
// 16:1 select mux. The bank is writable only while idle. A pass steps SEL
// through 0..TAPS-1 (HOLD freezes it) and then pulses DONE for one cycle.
module imem_tap_sequencer #(
  parameter int n    = 16,
  parameter int logn = 4,
  parameter int TAPS = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [logn-1:0]   i_wr_addr,
  input  logic [n-1:0]      i_wr_data,
  input  logic              i_start,
  input  logic              i_hold,
  output logic              o_busy,
  output logic [logn-1:0]   o_sel,
  output logic              o_sel_valid,
  output logic              o_last,
  output logic              o_done,
  output logic [n*16-1:0]   o_coef_flat
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [logn-1:0] LAST_SEL = logn'(TAPS - 1);

  state_t                   r_state;
  logic [logn-1:0]          r_sel;
  logic                     r_busy;
  logic                     r_sel_valid;
  logic                     r_last;
  logic                     r_done;
  logic [TAPS-1:0][n-1:0]   r_bank;

  logic [logn-1:0]          w_sel_inc;
  logic                     w_wr_ok;

  assign w_sel_inc = r_sel + 1'b1;
  // the bank is locked for the whole pass, so writes only land while idle
  assign w_wr_ok   = (r_state == IDLE) && i_wr_en;

  // sequencer FSM; every output is a flop updated alongside the state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_busy      <= 1'b0;
      r_sel_valid <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state     <= RUN;
            r_sel       <= '0;
            r_busy      <= 1'b1;
            r_sel_valid <= 1'b1;
            r_last      <= 1'b0;
          end
        end
        RUN: begin
          if (!i_hold) begin
            if (r_sel == LAST_SEL) begin
              // SEL parks on the last tap through FIN; SEL_VALID drops
              r_state     <= FIN;
              r_sel_valid <= 1'b0;
              r_last      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_sel  <= w_sel_inc;
              r_last <= (w_sel_inc == LAST_SEL);
            end
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_sel   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_sel       <= '0;
          r_busy      <= 1'b0;
          r_sel_valid <= 1'b0;
          r_last      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  // coefficient bank; addresses >= TAPS match no entry and are dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        if (w_wr_ok && (i_wr_addr == logn'(k))) r_bank[k] <= i_wr_data;
      end
    end
  end

  // flatten the bank onto the 16-word mux input; unbuilt entries read 0
  for (genvar k = 0; k < 16; k++) begin : g_flat
    if (k < TAPS) begin : g_live
      assign o_coef_flat[k*n +: n] = r_bank[k];
    end else begin : g_zero
      assign o_coef_flat[k*n +: n] = '0;
    end
  end

  assign o_busy      = r_busy;
  assign o_sel       = r_sel;
  assign o_sel_valid = r_sel_valid;
  assign o_last      = r_last;
  assign o_done      = r_done;

endmodule

// File: tb/tb_imem_tap_sequencer.sv
// Directed bench for imem_tap_sequencer: a TAPS=16 instance for the main
// scenarios and a TAPS=4 instance for the short-bank boundary.
module tb_imem_tap_sequencer;

  logic         clk;
  logic         rst_n;
  logic         wr_en, start, hold;
  logic [3:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         busy, sel_valid, last, done;
  logic [3:0]   sel;
  logic [255:0] coef;

  logic         wr_en4, start4, hold4;
  logic [3:0]   wr_addr4;
  logic [15:0]  wr_data4;
  logic         busy4, sel_valid4, last4, done4;
  logic [3:0]   sel4;
  logic [255:0] coef4;

  integer total = 0;
  integer bad   = 0;

  imem_tap_sequencer #(.n(16), .logn(4), .TAPS(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_start(start), .i_hold(hold),
    .o_busy(busy), .o_sel(sel), .o_sel_valid(sel_valid), .o_last(last),
    .o_done(done), .o_coef_flat(coef)
  );

  imem_tap_sequencer #(.n(16), .logn(4), .TAPS(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en4), .i_wr_addr(wr_addr4),
    .i_wr_data(wr_data4), .i_start(start4), .i_hold(hold4),
    .o_busy(busy4), .o_sel(sel4), .o_sel_valid(sel_valid4), .o_last(last4),
    .o_done(done4), .o_coef_flat(coef4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are changed and outputs sampled at the falling edge.
  task automatic test_reset();
    logic [7:0] outs;
    // load something and start a pass so reset has state to clear
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'h1234; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    outs = {busy, sel_valid, last, done, sel};
    total++;
    if (outs !== 8'h00) begin
      bad++; $display("FAIL reset_outs got=%h want=00", outs);
    end
    total++;
    if (coef !== 256'd0) begin
      bad++; $display("FAIL reset_coef got=%h want=0", coef[31:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (coef !== 256'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_release coef=%h busy=%b want 0/0", coef[31:0], busy);
    end
  endtask

  task automatic test_load_pass();
    logic [255:0] exp_coef;
    exp_coef = '0;
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1; wr_addr = 4'(k); wr_data = 16'h0100 + 16'(k);
      exp_coef[k*16 +: 16] = 16'h0100 + 16'(k);
      @(negedge clk);
    end
    wr_en = 1'b0;
    total++;
    if (coef !== exp_coef) begin
      bad++; $display("FAIL load_coef got=%h want=%h", coef[63:0], exp_coef[63:0]);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (sel !== 4'(k) || sel_valid !== 1'b1 || last !== (k == 15) || done !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL pass_step k=%0d sel=%0d vld=%b last=%b done=%b busy=%b", k, sel, sel_valid, last, done, busy);
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || sel_valid !== 1'b0 || last !== 1'b0) begin
      bad++; $display("FAIL pass_done done=%b busy=%b vld=%b last=%b want 1/1/0/0", done, busy, sel_valid, last);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL pass_idle done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_stall();
    int n5, got;
    n5 = 0; got = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // c=0 is the first SEL=0 cycle; unstalled DONE would be at c=16
    for (int c = 0; c < 60 && got < 0; c++) begin
      if (done === 1'b1) got = c;
      if (sel_valid === 1'b1 && sel === 4'd5) begin
        n5++;
        hold = (n5 <= 3);
      end else begin
        hold = 1'b0;
      end
      @(negedge clk);
    end
    hold = 1'b0;
    total++;
    if (n5 !== 4) begin
      bad++; $display("FAIL stall_sel5_cycles got=%0d want=4", n5);
    end
    total++;
    if (got !== 19) begin
      bad++; $display("FAIL stall_done_cycle got=%0d want=19", got);
    end
  endtask

  task automatic test_locked_bank();
    int got;
    got = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 60 && got < 0; c++) begin
      if (done === 1'b1) got = c;
      wr_en = (c == 3); wr_addr = 4'd2; wr_data = 16'hDEAD;
      start = (c == 5);
      if (c == 6) begin
        total++;
        if (sel !== 4'd6) begin
          bad++; $display("FAIL locked_restart sel=%0d want=6", sel);
        end
      end
      @(negedge clk);
    end
    wr_en = 1'b0; start = 1'b0;
    total++;
    if (got !== 16) begin
      bad++; $display("FAIL locked_done_cycle got=%0d want=16", got);
    end
    total++;
    if (coef[47:32] !== 16'h0102 || busy !== 1'b0) begin
      bad++; $display("FAIL locked_bank2 got=%h busy=%b want=0102/0", coef[47:32], busy);
    end
  endtask

  task automatic test_write_start_same_cycle();
    int got;
    got = -1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hBEEF; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    total++;
    if (sel !== 4'd0 || sel_valid !== 1'b1 || coef[15:0] !== 16'hBEEF) begin
      bad++; $display("FAIL same_cycle sel=%0d vld=%b coef0=%h want 0/1/beef", sel, sel_valid, coef[15:0]);
    end
    for (int c = 0; c < 60 && got < 0; c++) begin
      if (done === 1'b1) got = c;
      @(negedge clk);
    end
    total++;
    if (got !== 16) begin
      bad++; $display("FAIL same_cycle_done got=%0d want=16", got);
    end
  endtask

  // START held high: FIN ignores it, one idle cycle, then a new pass begins
  task automatic test_back_to_back();
    int got;
    logic [2:0] seen;
    got = -1;
    start = 1'b1;
    for (int c = 0; c < 60 && got < 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) got = c;
    end
    @(negedge clk);
    seen = {busy, sel_valid, done};
    total++;
    if (got < 0 || seen !== 3'b000) begin
      bad++; $display("FAIL b2b_gap got=%b done_at=%0d want=000", seen, got);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (sel_valid !== 1'b1 || sel !== 4'd0) begin
      bad++; $display("FAIL b2b_restart vld=%b sel=%0d want 1/0", sel_valid, sel);
    end
    got = -1;
    for (int c = 0; c < 60 && got < 0; c++) begin
      if (done === 1'b1) got = c;
      @(negedge clk);
    end
  endtask

  task automatic test_taps4();
    int got;
    got = -1;
    wr_en4 = 1'b1; wr_addr4 = 4'd9; wr_data4 = 16'hFFFF;
    @(negedge clk);
    wr_addr4 = 4'd3; wr_data4 = 16'h0033;
    @(negedge clk);
    wr_en4 = 1'b0;
    total++;
    if (coef4[255:64] !== 192'd0 || coef4[63:48] !== 16'h0033) begin
      bad++; $display("FAIL t4_bank hi=%h w3=%h want 0/0033", coef4[255:64], coef4[63:48]);
    end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 0; c < 20 && got < 0; c++) begin
      if (done4 === 1'b1) got = c;
      else if (c < 4) begin
        total++;
        if (sel4 !== 4'(c) || sel_valid4 !== 1'b1 || last4 !== (c == 3)) begin
          bad++; $display("FAIL t4_step c=%0d sel=%0d vld=%b last=%b", c, sel4, sel_valid4, last4);
        end
      end
      @(negedge clk);
    end
    total++;
    if (got !== 4) begin
      bad++; $display("FAIL t4_done_cycle got=%0d want=4", got);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; hold = 1'b0;
    wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = '0; start4 = 1'b0; hold4 = 1'b0;
    #12;
    total++;
    if ({busy, sel_valid, last, done, sel} !== 8'h00 || coef !== 256'd0) begin
      bad++; $display("FAIL por_state outs=%h", {busy, sel_valid, last, done, sel});
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_load_pass();
    test_stall();
    test_locked_bank();
    test_write_start_same_cycle();
    test_back_to_back();
    test_taps4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
